// File: rtl/menu_pkg.sv
// Shared types and width helpers for the front-panel menu controller.
// Pure declarations: no latency and no flow control.
package menu_pkg;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    SWITCH = 2'd1,
    ADC    = 2'd2,
    SCAN   = 2'd3
  } menu_mode_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ch_w(input int num_ch);
    return idx_w(num_ch);
  endfunction

  function automatic int sc_w(input int num_scale);
    return idx_w(num_scale);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects one raw push-button; press pulses one cycle.
// Latency 2 + DB_CYCLES cycles from a settled raw level to press; no backpressure.
module button_conditioner #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES);

  logic          sync1_q, sync2_q;
  logic [1:0]    vld_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          prev_q;
  logic          armed_q, armed_d;
  logic          cand;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld_q   <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
      armed_q <= armed_d;
    end
  end

  // Until a released (low) level has been seen after reset, the counter hunts
  // for a stable 0 instead of a level change, so a held button cannot fire.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    armed_d = armed_q;
    cand    = armed_q ? (sync2_q != level_q) : !sync2_q;
    if (vld_q[1]) begin
      if (cand) begin
        if (cnt_q == CW'(DB_CYCLES - 1)) begin
          cnt_d = '0;
          if (armed_q) level_d = sync2_q;
          else         armed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign press = level_q & ~prev_q;

endmodule

// File: rtl/menu_ctrl_n.sv
// Front-panel menu: mode FSM, channel/view indices, scan timer and display word select.
// Press to bin_out DB_CYCLES+4 cycles, data to bin_out 1 cycle; no backpressure.
module menu_ctrl_n
  import menu_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int NUM_SCALE  = 3,
  parameter int DATA_W     = 16,
  parameter int DB_CYCLES  = 1_000_000,
  parameter int SCAN_TICKS = 100_000_000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               btn_mode,
  input  logic                               btn_scale,
  input  logic                               btn_fmt,
  input  logic                               btn_ch,
  input  logic [DATA_W-1:0]                  switches_in,
  input  logic [NUM_CH*NUM_SCALE*DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0]                  bcd_in,
  output logic [DATA_W-1:0]                  bin_out,
  output logic [DATA_W-1:0]                  seg_out,
  output logic [NUM_CH-1:0]                  chan_en,
  output logic [ch_w(NUM_CH)-1:0]            chan_idx,
  output logic [sc_w(NUM_SCALE)-1:0]         scale_idx,
  output logic [1:0]                         mode,
  output logic                               fmt_bcd
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int SC_W = sc_w(NUM_SCALE);
  localparam int TW   = $clog2(SCAN_TICKS);

  logic press_mode, press_scale, press_fmt, press_ch;

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_mode (
    .clk(clk), .reset(reset), .btn_raw(btn_mode), .press(press_mode));
  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_scale (
    .clk(clk), .reset(reset), .btn_raw(btn_scale), .press(press_scale));
  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_fmt (
    .clk(clk), .reset(reset), .btn_raw(btn_fmt), .press(press_fmt));
  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_ch (
    .clk(clk), .reset(reset), .btn_raw(btn_ch), .press(press_ch));

  logic [DATA_W-1:0] adc_word [NUM_CH][NUM_SCALE];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar s = 0; s < NUM_SCALE; s++) begin : g_sc
      assign adc_word[c][s] = adc_data[(c*NUM_SCALE+s)*DATA_W +: DATA_W];
    end
  end

  menu_mode_t        mode_q, mode_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [SC_W-1:0]   scale_q, scale_d;
  logic              fmt_q, fmt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic              scan_tc;
  logic              chan_adv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= ZERO;
      chan_q  <= '0;
      scale_q <= '0;
      fmt_q   <= 1'b0;
      timer_q <= '0;
      bin_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      chan_q  <= chan_d;
      scale_q <= scale_d;
      fmt_q   <= fmt_d;
      timer_q <= timer_d;
      bin_q   <= bin_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    chan_d  = chan_q;
    scale_d = scale_q;
    fmt_d   = fmt_q;
    timer_d = '0;
    bin_d   = '0;

    if (press_mode) begin
      case (mode_q)
        ZERO:    mode_d = SWITCH;
        SWITCH:  mode_d = ADC;
        ADC:     mode_d = SCAN;
        default: mode_d = ZERO;
      endcase
    end

    // Timer idles at 0 outside SCAN, so entry always starts a full dwell.
    // Decisions use mode_q, so a terminal count still advances on the exit cycle.
    scan_tc  = (mode_q == SCAN) && (timer_q == TW'(SCAN_TICKS - 1));
    if (mode_q == SCAN && !scan_tc) timer_d = timer_q + TW'(1);

    chan_adv = scan_tc || (press_ch && mode_q != SCAN);
    if (chan_adv) chan_d = (chan_q == CH_W'(NUM_CH - 1)) ? '0 : chan_q + CH_W'(1);

    if (press_scale) scale_d = (scale_q == SC_W'(NUM_SCALE - 1)) ? '0 : scale_q + SC_W'(1);
    if (press_fmt)   fmt_d   = ~fmt_q;

    case (mode_q)
      ZERO:    bin_d = '0;
      SWITCH:  bin_d = switches_in;
      default: bin_d = adc_word[chan_q][scale_q];
    endcase
  end

  assign bin_out   = bin_q;
  assign seg_out   = fmt_q ? bcd_in : bin_q;
  assign chan_en   = NUM_CH'(1) << chan_q;
  assign chan_idx  = chan_q;
  assign scale_idx = scale_q;
  assign mode      = mode_q;
  assign fmt_bcd   = fmt_q;

endmodule
